// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Moore control FSM for the multi-cycle RV32I subset core. It sequences the
//   shared ALU and the single memory port through fetch, decode, execute,
//   memory and writeback. It also drives imm_sel, counts retired instructions,
//   and traps on unsupported encodings.
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   instr              instruction register (valid from DECODE onward)
//   zero               ALU zero flag (used in BRANCH)
//   mem_ready          memory completes the current request this cycle
//   mem_req/mem_we     memory strobe / write qualifier
//   iord               memory address select (0 PC, 1 ALUOut)
//   ir_write/pc_write  IR and PC load strobes; pc_src selects the PC source
//   reg_write          register-file write; mem_to_reg selects writeback data
//   alu_src_a/b/op     ALU operand muxes and operation select
//   imm_sel            immediate format (I/S/B/J)
//   state              current state (observation)
//   illegal            sticky trap flag
//   instret            retired-instruction counter (wraps)
module multicycle_ctrl #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_sel,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [RET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_TRAP   = 4'd15
  } state_t;

  state_t     st;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store;
  logic       retire;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  // Loads and stores share ADDR; opcode bit 5 separates them.
  assign is_store = instr[5];
  assign state    = st;

  // Register fields are consumed by the datapath, not by control.
  logic unused_instr;
  assign unused_instr = &{1'b0, instr[31:15], instr[11:7]};

  // An instruction retires on the edge that leaves its last state.
  always_comb begin
    retire = 1'b0;
    if (rst_n) begin
      case (st)
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: retire = 1'b1;
        S_MEM_WR:                            retire = mem_ready;
        default:                             retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_FETCH;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + RET_W'(1);
      case (st)
        S_FETCH:  if (mem_ready) st <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            7'b0110011: st <= S_EXEC_R;
            7'b0010011: st <= S_EXEC_I;
            7'b0000011,
            7'b0100011: st <= S_ADDR;
            7'b1100011: begin
              if (funct3 == 3'b000 || funct3 == 3'b001) st <= S_BRANCH;
              else begin st <= S_TRAP; illegal <= 1'b1; end
            end
            7'b1101111: st <= S_JAL;
            default:    begin st <= S_TRAP; illegal <= 1'b1; end
          endcase
        end
        S_EXEC_R, S_EXEC_I: st <= S_WB_ALU;
        S_ADDR:   st <= is_store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (mem_ready) st <= S_WB_MEM;
        S_MEM_WR: if (mem_ready) st <= S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: st <= S_FETCH;
        S_TRAP:   illegal <= 1'b1;
        // Unused encodings are treated as a trap rather than silently recovered.
        default:  begin st <= S_TRAP; illegal <= 1'b1; end
      endcase
    end
  end

  // Outputs decode from the registered state. mem_ready and zero qualify the
  // FETCH and BRANCH strobes, so those paths are combinational on the inputs.
  // Holding rst_n low forces every output to 0 and abandons any open request.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    imm_sel    = 2'd0;
    if (rst_n) begin
      case (st)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd2;
          imm_sel   = 2'd2;
        end
        S_EXEC_R: begin
          alu_src_a = 2'd1;
          alu_op    = 2'd2;
        end
        S_EXEC_I: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          alu_op    = 2'd2;
        end
        S_ADDR: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          imm_sel   = is_store ? 2'd1 : 2'd0;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_WB_ALU: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'd1;
          alu_op    = 2'd1;
          // funct3[0] turns BEQ into BNE.
          pc_write  = zero ^ funct3[0];
          pc_src    = 1'b1;
        end
        S_JAL: begin
          // The link value (old PC + 4) comes from the datapath directly.
          alu_src_a = 2'd2;
          alu_src_b = 2'd2;
          imm_sel   = 2'd3;
          pc_write  = 1'b1;
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int RET_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      instr = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic             reg_write, mem_to_reg, illegal;
  logic [1:0]       alu_src_a, alu_src_b, alu_op, imm_sel;
  logic [3:0]       state;
  logic [RET_W-1:0] instret;

  multicycle_ctrl #(.RET_W(RET_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_sel(imm_sel), .state(state), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h0000A103;
  localparam logic [31:0] SW  = 32'h0020A023;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] BNE = 32'h00209463;
  localparam logic [31:0] JAL = 32'h0000006F;
  localparam logic [31:0] BAD = 32'h0000007F;

  int n_chk = 0;
  int n_err = 0;
  int exp_ret = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are driven there.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // FETCH with zero-wait memory, then DECODE; returns after the DECODE edge.
  task automatic fetch_decode(input logic [31:0] ins);
    instr = ins;
    mem_ready = 1'b1;
    #1;
    check("fd_fetch_state", 32'(state), 32'd0);
    check("fd_ir_write", 32'(ir_write), 32'd1);
    adv();
    mem_ready = 1'b0;
    #1;
    check("fd_decode_state", 32'(state), 32'd1);
    adv();
  endtask

  task automatic do_branch(input logic [31:0] ins, input logic z, input logic exp_pw);
    fetch_decode(ins);
    zero = z;
    #1;
    check("br_state", 32'(state), 32'd9);
    check("br_pc_write", 32'(pc_write), 32'(exp_pw));
    check("br_pc_src", 32'(pc_src), 32'd1);
    check("br_alu_op", 32'(alu_op), 32'd1);
    adv();
    exp_ret++;
    check("br_retire", 32'(instret), 32'(exp_ret % 16));
    check("br_back_fetch", 32'(state), 32'd0);
  endtask

  int exp_st [11] = '{0, 0, 0, 0, 1, 4, 5, 5, 5, 5, 8};

  initial begin
    int ir_cnt;
    int bad_strobe;

    // Reset state; outputs forced low while rst_n=0.
    adv(); adv();
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_alu_src_b", 32'(alu_src_b), 32'd0);

    // ADD with zero-wait memory: 0,1,2,7,0.
    rst_n = 1'b1;
    instr = ADD;
    mem_ready = 1'b1;
    #1;
    check("add_f_mem_req", 32'(mem_req), 32'd1);
    check("add_f_alu_src_b", 32'(alu_src_b), 32'd1);
    check("add_f_pc_write", 32'(pc_write), 32'd1);
    check("add_f_reg_write", 32'(reg_write), 32'd0);
    adv();
    check("add_d_state", 32'(state), 32'd1);
    check("add_d_muxes", 32'({alu_src_a, alu_src_b, imm_sel}), 32'b10_10_10);
    check("add_d_reg_write", 32'(reg_write), 32'd0);
    adv();
    check("add_x_state", 32'(state), 32'd2);
    check("add_x_ctrl", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_00_10);
    check("add_x_reg_write", 32'(reg_write), 32'd0);
    adv();
    check("add_wb_state", 32'(state), 32'd7);
    check("add_wb_reg_write", 32'(reg_write), 32'd1);
    check("add_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
    adv();
    exp_ret++;
    check("add_done_state", 32'(state), 32'd0);
    check("add_instret", 32'(instret), 32'(exp_ret));

    // LW with 3 wait cycles on each memory access.
    instr = LW;
    ir_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      mem_ready = (c == 3 || c == 9);
      #1;
      check($sformatf("lw_state_c%0d", c), 32'(state), 32'(exp_st[c]));
      check($sformatf("lw_mem_req_c%0d", c), 32'(mem_req),
            32'((c <= 3) || (c >= 6 && c <= 9)));
      check($sformatf("lw_iord_c%0d", c), 32'(iord), 32'(c >= 6 && c <= 9));
      if (c == 5) check("lw_addr_imm_sel", 32'(imm_sel), 32'd0);
      if (c == 10) check("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
      ir_cnt += int'(ir_write);
      adv();
    end
    exp_ret++;
    check("lw_ir_write_count", 32'(ir_cnt), 32'd1);
    check("lw_instret", 32'(instret), 32'(exp_ret));
    check("lw_back_fetch", 32'(state), 32'd0);

    // Branches: BEQ takes on zero=1, BNE on zero=0.
    do_branch(BEQ, 1'b1, 1'b1);
    do_branch(BEQ, 1'b0, 1'b0);
    do_branch(BNE, 1'b1, 1'b0);
    do_branch(BNE, 1'b0, 1'b1);

    // Illegal opcode: trap and stay with all strobes quiet.
    fetch_decode(BAD);
    #1;
    check("trap_state", 32'(state), 32'd15);
    bad_strobe = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      #1;
      if (mem_req || ir_write || pc_write || reg_write || state != 4'd15) bad_strobe++;
      adv();
    end
    check("trap_no_strobes", 32'(bad_strobe), 32'd0);
    check("trap_illegal", 32'(illegal), 32'd1);
    check("trap_instret", 32'(instret), 32'(exp_ret));

    // Reset clears the trap; SW, then reset drops in MEM_WR mid-wait.
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    exp_ret = 0;
    #1;
    check("trap_cleared", 32'(illegal), 32'd0);
    fetch_decode(SW);
    #1;
    check("sw_addr_state", 32'(state), 32'd4);
    check("sw_addr_imm_sel", 32'(imm_sel), 32'd1);
    adv();
    mem_ready = 1'b0;
    #1;
    check("sw_mem_wr_state", 32'(state), 32'd6);
    check("sw_mem_wr_strobes", 32'({mem_req, mem_we, iord}), 32'b111);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    adv();
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_instret", 32'(instret), 32'd0);
    check("rst_mid_mem_req_held", 32'(mem_req), 32'd0);
    rst_n = 1'b1;

    // 15 JALs fill the 4-bit counter; the following SW wraps it to 0.
    for (int k = 0; k < 15; k++) begin
      fetch_decode(JAL);
      #1;
      if (k == 0) begin
        check("jal_state", 32'(state), 32'd10);
        check("jal_strobes", 32'({pc_write, pc_src, reg_write, imm_sel}), 32'b1_0_1_11);
        check("jal_muxes", 32'({alu_src_a, alu_src_b}), 32'b10_10);
      end
      adv();
    end
    check("jal_instret_full", 32'(instret), 32'd15);
    fetch_decode(SW);
    adv();
    mem_ready = 1'b1;
    #1;
    check("wrap_mem_wr_state", 32'(state), 32'd6);
    adv();
    check("wrap_instret", 32'(instret), 32'd0);
    check("wrap_state", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
